// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, decode next-PC select encoding and
// the fetch sequencer states, plus next-PC select helpers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    SEQ = 3'd0,
    JR  = 3'd2,
    JMP = 3'd3,
    BNE = 3'd4,
    BEQ = 3'd5
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Unlisted select codes (1, 6, 7) fall through to sequential fetch.
  function automatic logic redirect_taken(input logic [2:0] pcsrc,
                                          input logic       zero);
    logic taken;
    taken = 1'b0;
    case (pcsrc)
      JR, JMP: taken = 1'b1;
      BNE:     taken = ~zero;
      BEQ:     taken = zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic word_t redirect_target(input logic [2:0]  pcsrc,
                                            input word_t       pc4,
                                            input word_t       jr_target,
                                            input word_t       branch_offset,
                                            input logic [25:0] jump_index);
    word_t tgt;
    tgt = pc4 + branch_offset;
    case (pcsrc)
      JR:      tgt = jr_target;
      JMP:     tgt = {pc4[31:28], jump_index, 2'b00};
      default: tgt = pc4 + branch_offset;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on enable, flush clears only the valid bit,
// synchronous active-low reset clears everything.
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  input  logic  flush,
  input  word_t imemload_in,
  input  word_t pc_plus4_in,
  output word_t imemload,
  output word_t pc_plus4,
  output logic  valid
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      imemload <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      imemload <= imemload_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch sequencer with one-entry skid buffer,
// redirect/halt handling and IF/ID register. Optional FETCH_PERF_EN adds counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
)
(
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output word_t       imemaddr,
  input  logic        ihit,
  input  word_t       imemload_in,
  input  logic        stall,
  input  logic [2:0]  PCsrc,
  input  logic        zero,
  input  word_t       rdat1,
  input  word_t       BranchAddr,
  input  logic [25:0] addr,
  input  logic        halt,
  output word_t       imemload,
  output word_t       pc_plus4,
  output logic        valid
`ifdef FETCH_PERF_EN
  ,
  output word_t       fetch_count,
  output word_t       stall_count
`endif
);

  fetch_state_t state;
  word_t        pc;
  word_t        pc_next4;
  word_t        skid_word;
  word_t        skid_pc4;
  logic         iren_q;

  logic         take_halt;
  logic         take_redirect;
  word_t        target;

  logic         ifid_en;
  logic         ifid_flush;
  word_t        ifid_word;
  word_t        ifid_pc4;

  assign imemaddr = pc;
  assign iREN     = iren_q;
  assign pc_next4 = pc + 32'd4;

  // valid is only ever 1 outside HALTED, so halt needs no state qualifier.
  assign take_halt     = halt && valid;
  assign take_redirect = !stall && valid && redirect_taken(PCsrc, zero);
  assign target        = redirect_target(PCsrc, pc_plus4, rdat1, BranchAddr, addr);

  always_comb begin
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    ifid_word  = imemload_in;
    ifid_pc4   = pc_next4;
    case (state)
      FETCH: begin
        if (take_halt || take_redirect) begin
          ifid_flush = 1'b1;
        end else if (!stall) begin
          if (ihit) begin
            ifid_en = 1'b1;
          end else begin
            ifid_flush = 1'b1;
          end
        end
      end
      HOLD: begin
        ifid_word = skid_word;
        ifid_pc4  = skid_pc4;
        if (take_halt || take_redirect) begin
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_en = 1'b1;
        end
      end
      default: begin
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      skid_word <= '0;
      skid_pc4  <= '0;
      iren_q    <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (take_halt) begin
            state  <= HALTED;
            iren_q <= 1'b0;
          end else if (take_redirect) begin
            pc <= target;
          end else if (stall) begin
            if (ihit) begin
              skid_word <= imemload_in;
              skid_pc4  <= pc_next4;
              state     <= HOLD;
              iren_q    <= 1'b0;
            end
          end else if (ihit) begin
            pc <= pc_next4;
          end
        end
        HOLD: begin
          // PC was held on capture, so pc_next4 equals the buffered PC+4.
          if (take_halt) begin
            state     <= HALTED;
            skid_word <= '0;
            skid_pc4  <= '0;
          end else if (take_redirect) begin
            pc        <= target;
            state     <= FETCH;
            iren_q    <= 1'b1;
            skid_word <= '0;
            skid_pc4  <= '0;
          end else if (!stall) begin
            pc        <= pc_next4;
            state     <= FETCH;
            iren_q    <= 1'b1;
            skid_word <= '0;
            skid_pc4  <= '0;
          end
        end
        HALTED: begin
          iren_q <= 1'b0;
        end
        default: begin
          state  <= FETCH;
          iren_q <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .CLK         (CLK),
    .nRST        (nRST),
    .en          (ifid_en),
    .flush       (ifid_flush),
    .imemload_in (ifid_word),
    .pc_plus4_in (ifid_pc4),
    .imemload    (imemload),
    .pc_plus4    (pc_plus4),
    .valid       (valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_en) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if ((state == FETCH && iren_q && !ihit) || state == HOLD) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, is the PC value loaded on reset.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, synchronous, active-low.
REQ-004 iREN  out  1  instruction memory read request.
REQ-005 imemaddr  out  32  fetch address, equal to the PC register.
REQ-006 ihit  in  1  imemload_in valid this cycle.
REQ-007 imemload_in  in  32  instruction word from memory.
REQ-008 stall  in  1  decode hold; IF/ID contents and PC frozen.
REQ-009 PCsrc  in  3  decode next-PC select: 0 seq, 2 JR, 3 J/JAL, 4 BNE, 5 BEQ; others seq.
REQ-010 zero  in  1  ALU zero flag for the decode-stage branch.
REQ-011 rdat1  in  32  JR target.
REQ-012 BranchAddr  in  32  sign-extended, shifted branch offset.
REQ-013 addr  in  26  jump index.
REQ-014 halt  in  1  decode-stage HALT.
REQ-015 imemload  out  32  IF/ID instruction to decode.
REQ-016 pc_plus4  out  32  IF/ID PC+4 of imemload.
REQ-017 valid  out  1  IF/ID holds a live instruction.

Function
REQ-018 The FSM shall have states FETCH, HOLD and HALTED.
REQ-019 FETCH: iREN=1; on ihit with stall=0, the block shall register imemload<=imemload_in, pc_plus4<=PC+4, valid<=1, PC<=PC+4 in the same edge.
REQ-020 FETCH with ihit=1 and stall=1: the block shall capture the word and PC+4 in a one-entry skid buffer, hold the PC, and go to HOLD.
REQ-021 FETCH with ihit=0 and stall=0: valid<=0; PC held.
REQ-022 HOLD: iREN=0; when stall drops, the buffer shall load into IF/ID with valid=1, PC advances, and the FSM returns to FETCH.
REQ-023 Redirect is taken when stall=0 and valid=1 and (PCsrc=2, 3, 4 with zero=0, or 5 with zero=1).
REQ-024 Targets: JR=rdat1; J={pc_plus4[31:28],addr,2'b00}; branch=pc_plus4+BranchAddr, 32-bit wrap.
REQ-025 On redirect: PC<=target, valid<=0 next cycle, any in-flight ihit word and any skid buffer discarded, FSM to FETCH.
REQ-026 Priority when simultaneous: reset > halt > redirect > stall > sequential fetch.
REQ-027 halt=1 with valid=1 shall enter HALTED: iREN=0, valid=0, PC frozen, sticky until reset.
REQ-028 PC+4 at 32'hFFFFFFFC shall wrap to 0 without error.
REQ-029 imemaddr shall be combinational from the PC register, so there are zero cycles from redirect edge to new address.

Reset
REQ-030 With nRST=0 at an edge: PC=PC_INIT, FSM=FETCH, imemload=0, pc_plus4=0, valid=0, skid buffer empty, counters 0.
REQ-031 A reset mid-HOLD or mid-HALTED shall override all other inputs in that edge.

Configuration
REQ-032 FETCH_PERF_EN defined: the block shall add outputs fetch_count (32) and stall_count (32).
REQ-033 fetch_count shall increment per IF/ID load with valid=1.
REQ-034 stall_count shall increment per cycle in FETCH with iREN=1 and ihit=0, or in HOLD; both counters wrap.
REQ-035 FETCH_PERF_EN undefined: the ports and logic shall be absent, and behaviour shall otherwise be identical.

Structure
REQ-036 word_t and a pcsrc_t enum (SEQ=0, JR=2, JMP=3, BNE=4, BEQ=5) shall live in cpu_types_pkg.
REQ-037 The IF/ID register shall be a sub-module if_id_reg with enable, flush, and sync active-low reset.

Verification
REQ-038 Reset then ihit every cycle: imemaddr 0,4,8; valid rises 1 cycle after first ihit; pc_plus4=4.
REQ-039 ihit=1 with stall=1 for 3 cycles: imemaddr held and word buffered; after stall drops, imemload equals the buffered word and iREN resumes.
REQ-040 PCsrc=5, zero=1, pc_plus4=0x10, BranchAddr=0x20: next imemaddr=0x30, valid=0 for one cycle; same case with zero=0 gives sequential fetch.
REQ-041 PCsrc=3, addr=0x40, pc_plus4=0x80000004: imemaddr=0x80000100; with PCsrc=2, rdat1=0x200: imemaddr=0x200.
REQ-042 halt=1 together with PCsrc=3: HALTED entered with iREN=0 and PC unchanged; nRST=0 returns PC to PC_INIT.
REQ-043 With FETCH_PERF_EN: 5 fetches and 2 wait cycles give fetch_count=5 and stall_count=2.
